// File: rtl/linebuffer_window.sv
// Multi-row line buffer: turns a raster pixel stream into LINE_N vertically aligned taps,
// one per image row, with column/row tracking and top-border handling.
module linebuffer_window #(
    parameter int IMG_WIDTH_DATA = 24,
    parameter int IMG_WIDTH_LINE = 800,
    parameter int LINE_N         = 3,
    parameter int BORDER_MODE    = 0
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 i_sof,
    input  logic                                 i_de,
    input  logic [IMG_WIDTH_DATA-1:0]            din,
    output logic                                 o_line_de,
    output logic [LINE_N*IMG_WIDTH_DATA-1:0]     dout_taps,
    output logic [$clog2(IMG_WIDTH_LINE)-1:0]    o_col,
    output logic                                 o_row_full
);

    localparam int W     = IMG_WIDTH_DATA;
    localparam int M     = LINE_N - 1;
    localparam int COL_W = $clog2(IMG_WIDTH_LINE);
    localparam int ROW_W = $clog2(LINE_N);

    logic [COL_W-1:0] col_q, col_d, col_eff;
    logic [ROW_W-1:0] row_q, row_d, row_eff;
    logic             line_de_q, line_de_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic             row_full_q, row_full_d;

    logic [W-1:0] rd_data [M];
    logic [W-1:0] wr_data [M];
    logic [W-1:0] raw_tap [LINE_N];
    logic [W-1:0] tap_d   [LINE_N];
    logic [W-1:0] tap_q   [LINE_N];

    // A frame start forces this beat to column 0 / row 0 instead of incrementing.
    always_comb begin
        col_eff = i_sof ? '0 : col_q;
        row_eff = i_sof ? '0 : row_q;
    end

    // Row cascade: memory k takes the pre-write contents of memory k-1 at the same column.
    for (genvar gi = 0; gi < M; gi++) begin : g_mem
        logic [W-1:0] line_mem [IMG_WIDTH_LINE];

        if (gi == 0) begin : g_first
            assign wr_data[gi] = din;
        end else begin : g_next
            assign wr_data[gi] = rd_data[gi-1];
        end

        assign rd_data[gi] = line_mem[col_eff];

        always_ff @(posedge clk) begin
            if (i_de) begin
                line_mem[col_eff] <= wr_data[gi];
            end
        end
    end

    always_comb begin
        raw_tap[0] = din;
        for (int k = 1; k < LINE_N; k++) begin
            raw_tap[k] = rd_data[k-1];
        end
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        line_de_d  = i_de;
        out_col_d  = out_col_q;
        row_full_d = row_full_q;
        for (int k = 0; k < LINE_N; k++) begin
            tap_d[k] = tap_q[k];
        end
        if (i_de) begin
            out_col_d  = col_eff;
            row_full_d = (row_eff == ROW_W'(LINE_N - 1));
            if (col_eff == COL_W'(IMG_WIDTH_LINE - 1)) begin
                col_d = '0;
                row_d = (row_eff == ROW_W'(LINE_N - 1)) ? row_eff : row_eff + 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
                row_d = row_eff;
            end
            // Taps reaching above the frame top are replaced according to the border mode.
            for (int k = 0; k < LINE_N; k++) begin
                if (k <= int'(row_eff)) begin
                    tap_d[k] = raw_tap[k];
                end else if (BORDER_MODE == 1) begin
                    tap_d[k] = '0;
                end else if (BORDER_MODE == 2) begin
                    tap_d[k] = raw_tap[row_eff];
                end else begin
                    tap_d[k] = raw_tap[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q      <= '0;
            row_q      <= '0;
            line_de_q  <= 1'b0;
            out_col_q  <= '0;
            row_full_q <= 1'b0;
            for (int k = 0; k < LINE_N; k++) begin
                tap_q[k] <= '0;
            end
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            line_de_q  <= line_de_d;
            out_col_q  <= out_col_d;
            row_full_q <= row_full_d;
            for (int k = 0; k < LINE_N; k++) begin
                tap_q[k] <= tap_d[k];
            end
        end
    end

    for (genvar gi = 0; gi < LINE_N; gi++) begin : g_pack
        assign dout_taps[gi*W +: W] = tap_q[gi];
    end

    assign o_line_de  = line_de_q;
    assign o_col      = out_col_q;
    assign o_row_full = row_full_q;

endmodule

// File: tb/tb_linebuffer_window.sv
// Scoreboard bench: three line buffers (zero-fill, replicate, and a 5-row 800-wide raw one)
// checked against a pixel-history model of the current frame.
module tb_linebuffer_window;

    typedef struct {
        logic [127:0] taps;
        logic [127:0] mask;
        int           col;
        bit           full;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 3-row, 8-wide instances
    logic        a_sof = 1'b0, a_de = 1'b0;
    logic [7:0]  a_din = '0;
    logic        a_line_de, b_line_de;
    logic [23:0] a_taps, b_taps;
    logic [2:0]  a_col, b_col;
    logic        a_full, b_full;

    logic        c_sof = 1'b0, c_de = 1'b0;
    logic [15:0] c_din = '0;
    logic        c_line_de;
    logic [79:0] c_taps;
    logic [9:0]  c_col;
    logic        c_full;

    linebuffer_window #(.IMG_WIDTH_DATA(8), .IMG_WIDTH_LINE(8), .LINE_N(3), .BORDER_MODE(1)) u_a (
        .clk(clk), .reset_n(reset_n), .i_sof(a_sof), .i_de(a_de), .din(a_din),
        .o_line_de(a_line_de), .dout_taps(a_taps), .o_col(a_col), .o_row_full(a_full));

    linebuffer_window #(.IMG_WIDTH_DATA(8), .IMG_WIDTH_LINE(8), .LINE_N(3), .BORDER_MODE(2)) u_b (
        .clk(clk), .reset_n(reset_n), .i_sof(a_sof), .i_de(a_de), .din(a_din),
        .o_line_de(b_line_de), .dout_taps(b_taps), .o_col(b_col), .o_row_full(b_full));

    linebuffer_window #(.IMG_WIDTH_DATA(16), .IMG_WIDTH_LINE(800), .LINE_N(5), .BORDER_MODE(0)) u_c (
        .clk(clk), .reset_n(reset_n), .i_sof(c_sof), .i_de(c_de), .din(c_din),
        .o_line_de(c_line_de), .dout_taps(c_taps), .o_col(c_col), .o_row_full(c_full));

    int tests = 0;
    int fails = 0;

    exp_t qa[$], qb[$], qc[$];
    logic [7:0]  hist_ab [16][8];
    logic [15:0] hist_c  [10][800];
    int ab_row = 0, ab_col = 0;
    int c_row = 0, c_col_m = 0;
    logic de_seen = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp,
                       input logic [127:0] mask);
        tests++;
        if (((act ^ exp) & mask) !== 128'd0) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act & mask, exp & mask);
        end
    endtask

    task automatic ab_beat(input bit sof, input logic [7:0] pix);
        exp_t ea, eb;
        logic [7:0] v;
        @(posedge clk);
        #1;
        a_sof = sof; a_de = 1'b1; a_din = pix;
        if (sof) begin ab_row = 0; ab_col = 0; end
        hist_ab[ab_row][ab_col] = pix;
        ea.taps = '0; eb.taps = '0;
        ea.mask = '1; eb.mask = '1;
        for (int k = 0; k < 3; k++) begin
            if (ab_row >= k) begin
                v = hist_ab[ab_row-k][ab_col];
                ea.taps[k*8 +: 8] = v;
                eb.taps[k*8 +: 8] = v;
            end else begin
                ea.taps[k*8 +: 8] = 8'h00;
                eb.taps[k*8 +: 8] = hist_ab[0][ab_col];
            end
        end
        ea.col = ab_col; eb.col = ab_col;
        ea.full = (ab_row >= 2); eb.full = ea.full;
        qa.push_back(ea); qb.push_back(eb);
        $display("[TB] AB beat sof=%0d row=%0d col=%0d din=%02h exp_a=%06h exp_b=%06h",
                 sof, ab_row, ab_col, pix, ea.taps[23:0], eb.taps[23:0]);
        ab_col++;
        if (ab_col == 8) begin ab_col = 0; ab_row++; end
    endtask

    task automatic ab_idle(input bit sof);
        @(posedge clk);
        #1;
        a_sof = sof; a_de = 1'b0; a_din = 8'hEE;
    endtask

    task automatic c_beat(input bit sof, input logic [15:0] pix);
        exp_t e;
        @(posedge clk);
        #1;
        c_sof = sof; c_de = 1'b1; c_din = pix;
        if (sof) begin c_row = 0; c_col_m = 0; end
        hist_c[c_row][c_col_m] = pix;
        e.taps = '0; e.mask = '0;
        for (int k = 0; k < 5; k++) begin
            if (c_row >= k) begin
                e.taps[k*16 +: 16] = hist_c[c_row-k][c_col_m];
                e.mask[k*16 +: 16] = 16'hFFFF;
            end
        end
        e.col = c_col_m;
        e.full = (c_row >= 4);
        qc.push_back(e);
        c_col_m++;
        if (c_col_m == 800) begin c_col_m = 0; c_row++; end
    endtask

    task automatic ab_ramp(input int rows, input bit gaps);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (gaps) begin
                    while ($urandom_range(1) == 1) ab_idle($urandom_range(3) == 0);
                end
                ab_beat(r == 0 && c == 0, 8'(r*16 + c));
            end
        end
    endtask

    always @(posedge clk) de_seen <= a_de;

    exp_t ma, mb, mc;
    always @(negedge clk) begin
        if (reset_n) begin
            chk("line_de_delay", 128'(a_line_de), 128'(de_seen), '1);
            if (a_line_de) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_output", 128'(1), 128'(0), '1);
                end else begin
                    ma = qa.pop_front();
                    chk("a_taps", 128'(a_taps), ma.taps, ma.mask);
                    chk("a_col", 128'(a_col), 128'(ma.col), '1);
                    chk("a_row_full", 128'(a_full), 128'(ma.full), '1);
                end
            end
            if (b_line_de) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_output", 128'(1), 128'(0), '1);
                end else begin
                    mb = qb.pop_front();
                    chk("b_taps", 128'(b_taps), mb.taps, mb.mask);
                    chk("b_col", 128'(b_col), 128'(mb.col), '1);
                    chk("b_row_full", 128'(b_full), 128'(mb.full), '1);
                end
            end
            if (c_line_de) begin
                if (qc.size() == 0) begin
                    chk("c_unexpected_output", 128'(1), 128'(0), '1);
                end else begin
                    mc = qc.pop_front();
                    chk("c_taps", 128'(c_taps), mc.taps, mc.mask);
                    chk("c_col", 128'(c_col), 128'(mc.col), '1);
                    chk("c_row_full", 128'(c_full), 128'(mc.full), '1);
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_line_de"}, 128'(a_line_de), 128'(0), '1);
        chk({tag, "_a_taps"},    128'(a_taps),    128'(0), '1);
        chk({tag, "_a_col"},     128'(a_col),     128'(0), '1);
        chk({tag, "_a_full"},    128'(a_full),    128'(0), '1);
        chk({tag, "_b_taps"},    128'(b_taps),    128'(0), '1);
        chk({tag, "_c_taps"},    128'(c_taps),    128'(0), '1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_state");
        reset_n = 1'b1;

        $display("[TB] continuous ramp");
        ab_ramp(4, 1'b0);
        ab_idle(1'b0);

        $display("[TB] ramp with de gaps");
        ab_ramp(4, 1'b1);
        ab_idle(1'b0);

        $display("[TB] mid-line frame start");
        for (int i = 0; i < 20; i++) ab_beat(i == 0, 8'((i / 8) * 16 + (i % 8)));
        for (int i = 0; i < 16; i++) ab_beat(i == 0, 8'(8'h80 + i));
        ab_idle(1'b0);

        $display("[TB] asynchronous reset mid-frame");
        for (int i = 0; i < 12; i++) ab_beat(i == 0, 8'(8'h40 + i));
        ab_idle(1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        ab_row = 0; ab_col = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) ab_beat(1'b0, 8'(8'h60 + i));
        ab_idle(1'b0);

        $display("[TB] 5-row 800-wide frame");
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 800; c++) c_beat(r == 0 && c == 0, 16'(r*1000 + c));
        end
        @(posedge clk);
        #1;
        c_de = 1'b0; c_sof = 1'b0;

        repeat (5) ab_idle(1'b0);
        chk("a_queue_drained", 128'(qa.size()), 128'(0), '1);
        chk("b_queue_drained", 128'(qb.size()), 128'(0), '1);
        chk("c_queue_drained", 128'(qc.size()), 128'(0), '1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/linebuffer_window.md
# linebuffer_window

Parametrised multi-row line buffer for the binary and grey-scale morphology and filter IP cores. It turns a raster pixel stream into LINE_N vertically aligned taps, one per image row, presented one cycle after each input pixel. It tracks column and row position and handles the top image border by zero-fill or row replication. A frame-start input re-synchronises it at any time. It feeds the horizontal window shifters of the erode, dilate and convolution cores.

## Interface
- IMG_WIDTH_DATA, 24, bits per pixel
- IMG_WIDTH_LINE, 800, pixels per line (column counter modulus), 2..4096
- LINE_N, 3, number of row taps, 2..8
- BORDER_MODE, 0, top-border handling: 0 raw memory contents, 1 zero-fill, 2 replicate nearest valid row
- clk  input  1  pixel clock; all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- i_sof  input  1  frame start; qualified by i_de, marks the pixel at column 0, row 0
- i_de  input  1  input pixel valid
- din  input  IMG_WIDTH_DATA  input pixel
- o_line_de  output  1  output taps valid (i_de delayed 1 cycle)
- dout_taps  output  LINE_N*IMG_WIDTH_DATA  tap k in bits [k*W +: W]; tap 0 is the current row, tap k is k rows above
- o_col  output  clog2(IMG_WIDTH_LINE)  column of the current output taps
- o_row_full  output  1  high when all LINE_N taps hold real image rows (row index ≥ LINE_N-1)

## Operation
- Storage: LINE_N-1 line memories, each IMG_WIDTH_LINE x IMG_WIDTH_DATA, all addressed by the column counter.
- Each i_de beat:
  - Every memory is read at address col (read-before-write).
  - Memory 0 is written with din.
  - Memory k (k≥1) is written with the read data of memory k-1. This forms a row cascade.
- Tap 0 is din registered. Tap k (k≥1) is the registered read of memory k-1.
- Column counter:
  - Increments on each i_de beat.
  - Wraps from IMG_WIDTH_LINE-1 to 0; each wrap increments the row counter.
- Row counter: counts up and saturates at LINE_N-1. It only drives border logic and o_row_full.
- i_sof with i_de: this beat is column 0, row 0, regardless of counter state. Counters are forced, not incremented. Memory contents are not cleared.
- i_sof without i_de: ignored.
- Tap k is valid in the current frame when row ≥ k. Invalid taps are presented per BORDER_MODE:
  - 0: memory contents unchanged (stale or previous frame)
  - 1: all zeros
  - 2: copy of tap (row), the highest valid tap. Row 0 therefore replicates tap 0 into all taps.
- Gaps in i_de (blanking) do not advance any counter. Outputs hold their last value while o_line_de is 0.
- Reset: col=0, row=0, all output registers 0, o_row_full=0. Memory contents are undefined, not reset. Border modes 1/2 hide this for the first frame.

## Timing
- Latency 1 cycle: din at edge n appears on tap 0 at edge n+1 with o_line_de=1.
- o_col and o_row_full are registered alongside the taps and refer to the same pixel.
- Tap k at output column c equals the pixel at column c, k rows earlier, counting only i_de beats.
- Back-to-back i_de and arbitrary gaps are both supported; no backpressure.
- Simultaneous column wrap and i_sof: i_sof wins, so col=0 and row=0.
- Row saturation: o_row_full rises with the first output pixel of row LINE_N-1. It stays high until the next i_sof or reset.
- Asynchronous reset asserted mid-line: all outputs go to 0 immediately. After release the first i_de beat is treated as column 0, row 0, with or without i_sof.

## Test plan
- Ramp, LINE_N=3, IMG_WIDTH_LINE=8, BORDER_MODE=1, din = row*16+col for 4 rows, continuous de -> at row 2 col 5: taps = {0x05, 0x15, 0x25}; at row 1: tap2 = 0; o_row_full first high at row 2 col 0.
- BORDER_MODE=2, same stimulus -> row 0 col 3: all taps 0x03; row 1 col 3: tap1 = 0x03, tap2 = 0x03, tap0 = 0x13.
- Random de gaps (~50% duty) with the ramp -> tap values are identical to the continuous case. o_line_de equals i_de delayed by exactly 1 cycle. o_col advances only on de.
- Mid-line i_sof at col 4 of row 2 -> that pixel is reported with o_col=0. o_row_full drops on that output. BORDER_MODE=1 taps 1..2 are zero for that output.
- Assert reset_n low mid-frame for 3 cycles -> outputs are 0 asynchronously. The first de after release reports o_col=0, o_row_full=0.
- LINE_N=5, IMG_WIDTH_LINE=800, one full 10-line frame against a reference model -> all 5 taps match on every pixel. o_col wraps 799→0 at each line end.
